tlb_unit: RTL and testbench
===========================

# tlb_unit

Joint TLB for the PipelineMIPS core, sitting beside the CP0 register file. It translates instruction and data virtual addresses, supplies `tlbp` and `tlbr` results back into CP0, and commits `tlbwi` and `tlbwr` writes from the CP0 EntryHi, EntryLo0/1, PageMask, Index and Random values. Translation is combinational; entry state changes only at the clock edge.

## Interface
Parameters:
- `TLB_LINE_NUM`, 32: number of entries; must equal the `TLB_LINE_NUM` define.
- `IDX_W`, 5: log2(`TLB_LINE_NUM`).

Ports:
- `clk` in 1: clock; single clock domain.
- `rst` in 1: reset, synchronous, active-high.
- `stallW` in 1: when high, TLB writes are held off.
- `flush_exception` in 1: M-stage instruction is excepting; suppresses its TLB write.
- `tlb_typeM` in 4: {tlbwr, tlbwi, tlbr, tlbp}.
- `entry_hi_W`, `page_mask_W`, `entry_lo0_W`, `entry_lo1_W`, `index_W`, `random_W` in 32 each: current CP0 values.
- `k0` in 3: Config.K0, the kseg0 cacheability attribute.
- `inst_vaddr`, `data_vaddr` in 32 each: lookup addresses.
- `data_store` in 1: the data access is a store.
- `inst_paddr`, `data_paddr` out 32 each: physical addresses.
- `inst_uncached`, `data_uncached` out 1 each: the access bypasses the cache.
- `inst_refill`, `inst_invalid` out 1 each: instruction TLB exceptions.
- `data_refill`, `data_invalid`, `data_modify` out 1 each: data TLB exceptions.
- `entry_hi_in`, `page_mask_in`, `entry_lo0_in`, `entry_lo1_in`, `index_in` out 32 each: `tlbr`/`tlbp` results, driven into CP0.

## Operation
- Each entry holds VPN2[18:0], ASID[7:0], G, Mask[15:0], and for each of the even and odd pages PFN[19:0], C[2:0], D, V.
- **Segments.**
  - kseg0 (0x8000_0000–0x9FFF_FFFF): paddr = vaddr & 0x1FFF_FFFF; uncached = (k0 == 2).
  - kseg1 (0xA000_0000–0xBFFF_FFFF): same paddr mapping; always uncached.
  - All other addresses are mapped.
  - Unmapped accesses never raise TLB exceptions.
- **Match.** Entry i matches when both hold:
  - (VPN2_i ^ vaddr[31:13]) & ~{3'b0, Mask_i} == 0;
  - G_i, or ASID_i == entry_hi_W[7:0].
- **Multiple matches** resolve to the lowest index.
- **Page size.** Only 4 KB pages are translated. The odd/even page is selected by vaddr[12], and paddr = {PFN, vaddr[11:0]}. Mask affects only the compare and the `tlbr` readback.
- **Exceptions** (mapped accesses only):
  - No match: refill = 1.
  - Match with V = 0: invalid = 1.
  - Data store with V = 1 and D = 0: modify = 1.
  - At most one exception flag is high per port.
  - Uncached = (C == 2).
- **tlbp** uses entry_hi_W VPN2/ASID.
  - Hit: index_in = {1'b0, 26'b0, idx}.
  - Miss: index_in = 0x8000_0000.
- **tlbr** reads entry[index_W[IDX_W-1:0]].
  - entry_hi_in = {VPN2, 5'b0, ASID}.
  - page_mask_in = {3'b0, Mask, 13'b0}.
  - entry_lo0_in / entry_lo1_in = {6'b0, PFN, C, D, V, G}.
- **Writes.**
  - Write enable we = (tlbwi | tlbwr) & ~stallW & ~flush_exception.
  - Target index: index_W if tlbwi, else random_W. tlbwi wins if both are set.
  - Stored G = entry_lo0_W[0] & entry_lo1_W[0].
  - Stored VPN2 = entry_hi_W[31:13] & ~Mask.

## Timing
- Lookup, `tlbp` and `tlbr` outputs are combinational from inputs and current entry state. CP0 captures them at the next edge.
- A write commits at the posedge where we = 1.
  - A lookup in the same cycle sees the old contents.
  - The new contents are visible from the next cycle.
- A `tlbp` in the cycle immediately after a `tlbwi` must hit the newly written entry.
- Reset clears every field of every entry to 0. All exception outputs then depend only on the lookup. A mapped address in 0x0000_0000–0x0000_1FFF with ASID 0 matches entry 0 and returns invalid.
- Reset asserted in the same cycle as a write: reset wins and nothing is written.
- The tlbp/tlbr outputs are don't-care when the corresponding `tlb_typeM` bit is low, but they must stay free of X.

## Structure
- The shared package `tlb_pkg` holds:
  - the entry struct type;
  - segment boundary constants;
  - the `CACHE_UNCACHED` = 3'd2 constant;
  - field-position constants matching the CP0 bit defines (`VPN2_BITS`, `ASID_BITS`, `PFN_BITS`, `FLAG_BITS`, `MASK_BITS`).
- Sub-module `tlb_lookup`: one combinational match, priority-encode and page-select path. It is instantiated three times (inst, data, tlbp) against the shared entry array.

## Test plan
- **Reset, then kseg fetches.** inst_vaddr 0xBFC0_0000 → paddr 0x1FC0_0000, uncached = 1, no exception. data_vaddr 0x8000_1000 with k0 = 3 → paddr 0x0000_1000, uncached = 0.
- **tlbwi, then hit.**
  - Setup: index 5, EntryHi 0x0040_0012, Lo0 = {PFN 0x00123, C 3, D 1, V 1, G 0}, Lo1 = V 0.
  - data_vaddr 0x0040_0ABC with ASID 0x12 → paddr 0x0012_3ABC, no exception.
  - vaddr 0x0040_1ABC → invalid = 1.
  - ASID 0x13 → refill = 1.
- **Store to a D = 0 page** → data_modify = 1 and paddr still valid. The same address as a load raises no exception.
- **tlbp then tlbr.**
  - tlbp of the entry above → index_in = 5.
  - tlbp of 0x7000_0000 → index_in = 0x8000_0000.
  - tlbr with index_W = 5 → entry_lo0_in = 0x0000_48DE, entry_hi_in = 0x0040_0012.
- **tlbwr** writes at random_W = 17 (checked via tlbr of index 17). The same tlbwr with flush_exception = 1 or stallW = 1 leaves entry 17 unchanged.
- **Write/lookup same cycle.**
  - A lookup concurrent with a tlbwi to the matching VPN returns the old result (refill), then a hit on the next cycle.
  - rst coincident with tlbwi leaves all entries zero.

Source files
------------

// File: rtl/tlb_pkg.sv
// tlb_pkg: shared types and constants for the joint TLB.
//   tlb_entry_t  - one TLB line (VPN2/ASID/G/Mask plus even/odd page data)
//   KSEG*_BASE   - segment boundaries used to split unmapped/mapped space
//   *_LSB/_BITS  - CP0 register field positions (EntryHi/EntryLo/PageMask)
package tlb_pkg;

  localparam logic [31:0] KSEG0_BASE = 32'h8000_0000;
  localparam logic [31:0] KSEG1_BASE = 32'hA000_0000;
  localparam logic [31:0] KSEG2_BASE = 32'hC000_0000;

  localparam logic [2:0] CACHE_UNCACHED = 3'd2;

  // CP0 field positions: <name>_LSB is the low bit, <name>_BITS the width.
  localparam int VPN2_LSB  = 13;
  localparam int VPN2_BITS = 19;
  localparam int ASID_LSB  = 0;
  localparam int ASID_BITS = 8;
  localparam int PFN_LSB   = 6;
  localparam int PFN_BITS  = 20;
  localparam int FLAG_LSB  = 0;   // {C[2:0], D, V, G}
  localparam int FLAG_BITS = 6;
  localparam int MASK_LSB  = 13;
  localparam int MASK_BITS = 16;

  localparam int LO_G   = 0;
  localparam int LO_V   = 1;
  localparam int LO_D   = 2;
  localparam int LO_C   = 3;

  typedef struct packed {
    logic [VPN2_BITS-1:0] vpn2;
    logic [ASID_BITS-1:0] asid;
    logic                 g;
    logic [MASK_BITS-1:0] mask;
    logic [PFN_BITS-1:0]  pfn0;
    logic [2:0]           c0;
    logic                 d0;
    logic                 v0;
    logic [PFN_BITS-1:0]  pfn1;
    logic [2:0]           c1;
    logic                 d1;
    logic                 v1;
  } tlb_entry_t;

  // kseg0 and kseg1 together span 0x8000_0000..0xBFFF_FFFF.
  function automatic logic is_unmapped(input logic [31:0] va);
    return (va >= KSEG0_BASE) && (va < KSEG2_BASE);
  endfunction

  function automatic logic is_kseg1(input logic [31:0] va);
    return (va >= KSEG1_BASE) && (va < KSEG2_BASE);
  endfunction

endpackage

// File: rtl/tlb_lookup.sv
// tlb_lookup: combinational match / priority-encode / page-select over the
// whole entry array.
//   i_entries       - current TLB contents
//   i_vpn2, i_odd   - vaddr[31:13] and vaddr[12]
//   i_asid          - current ASID
//   o_hit, o_idx    - any match, lowest matching index
//   o_pfn/o_c/o_d/o_v - selected page data of the matching entry
module tlb_lookup
  import tlb_pkg::*;
#(
  parameter int N     = 32,
  parameter int IDX_W = 5
) (
  input  tlb_entry_t [N-1:0]     i_entries,
  input  logic [VPN2_BITS-1:0]   i_vpn2,
  input  logic                   i_odd,
  input  logic [ASID_BITS-1:0]   i_asid,
  output logic                   o_hit,
  output logic [IDX_W-1:0]       o_idx,
  output logic [PFN_BITS-1:0]    o_pfn,
  output logic [2:0]             o_c,
  output logic                   o_d,
  output logic                   o_v
);

  logic [N-1:0]  w_match;
  logic [IDX_W-1:0] w_idx;
  tlb_entry_t    w_sel;

  for (genvar gi = 0; gi < N; gi++) begin : g_match
    assign w_match[gi] =
      (((i_entries[gi].vpn2 ^ i_vpn2) & ~{3'b0, i_entries[gi].mask}) == '0) &&
      (i_entries[gi].g || (i_entries[gi].asid == i_asid));
  end

  // Scan high to low so the lowest matching index is the one left standing.
  always_comb begin
    w_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_match[i]) w_idx = IDX_W'(i);
    end
  end

  // On a miss w_idx is 0, so outputs come from entry 0: defined, never X.
  assign w_sel = i_entries[w_idx];
  assign o_hit = |w_match;
  assign o_idx = w_idx;
  assign o_pfn = i_odd ? w_sel.pfn1 : w_sel.pfn0;
  assign o_c   = i_odd ? w_sel.c1   : w_sel.c0;
  assign o_d   = i_odd ? w_sel.d1   : w_sel.d0;
  assign o_v   = i_odd ? w_sel.v1   : w_sel.v0;

endmodule

// File: rtl/tlb_unit.sv
// tlb_unit: joint instruction/data TLB beside CP0.
//   clk, rst            - clock, synchronous active-high reset
//   stallW, flush_exception - hold off / cancel the M-stage TLB write
//   tlb_typeM           - {tlbwr, tlbwi, tlbr, tlbp}
//   *_W, k0             - current CP0 register values
//   inst_/data_vaddr    - lookup addresses (data_store marks stores)
//   inst_/data_paddr, *_uncached, *_refill/_invalid/_modify - translation
//   entry_hi_in .. index_in - tlbr/tlbp results back to CP0
module tlb_unit
  import tlb_pkg::*;
#(
  parameter int TLB_LINE_NUM = 32,
  parameter int IDX_W        = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallW,
  input  logic        flush_exception,
  input  logic [3:0]  tlb_typeM,
  input  logic [31:0] entry_hi_W,
  input  logic [31:0] page_mask_W,
  input  logic [31:0] entry_lo0_W,
  input  logic [31:0] entry_lo1_W,
  input  logic [31:0] index_W,
  input  logic [31:0] random_W,
  input  logic [2:0]  k0,
  input  logic [31:0] inst_vaddr,
  input  logic [31:0] data_vaddr,
  input  logic        data_store,
  output logic [31:0] inst_paddr,
  output logic [31:0] data_paddr,
  output logic        inst_uncached,
  output logic        data_uncached,
  output logic        inst_refill,
  output logic        inst_invalid,
  output logic        data_refill,
  output logic        data_invalid,
  output logic        data_modify,
  output logic [31:0] entry_hi_in,
  output logic [31:0] page_mask_in,
  output logic [31:0] entry_lo0_in,
  output logic [31:0] entry_lo1_in,
  output logic [31:0] index_in
);

  tlb_entry_t [TLB_LINE_NUM-1:0] r_entries;

  logic [ASID_BITS-1:0] w_asid;
  assign w_asid = entry_hi_W[ASID_LSB +: ASID_BITS];

  // ---------------- lookups ----------------
  logic                 w_i_hit, w_d_hit, w_p_hit;
  logic [IDX_W-1:0]     w_i_idx, w_d_idx, w_p_idx;
  logic [PFN_BITS-1:0]  w_i_pfn, w_d_pfn, w_p_pfn;
  logic [2:0]           w_i_c, w_d_c, w_p_c;
  logic                 w_i_d, w_d_d, w_p_d;
  logic                 w_i_v, w_d_v, w_p_v;

  tlb_lookup #(.N(TLB_LINE_NUM), .IDX_W(IDX_W)) u_lkp_inst (
    .i_entries(r_entries), .i_vpn2(inst_vaddr[31:13]), .i_odd(inst_vaddr[12]),
    .i_asid(w_asid), .o_hit(w_i_hit), .o_idx(w_i_idx), .o_pfn(w_i_pfn),
    .o_c(w_i_c), .o_d(w_i_d), .o_v(w_i_v)
  );

  tlb_lookup #(.N(TLB_LINE_NUM), .IDX_W(IDX_W)) u_lkp_data (
    .i_entries(r_entries), .i_vpn2(data_vaddr[31:13]), .i_odd(data_vaddr[12]),
    .i_asid(w_asid), .o_hit(w_d_hit), .o_idx(w_d_idx), .o_pfn(w_d_pfn),
    .o_c(w_d_c), .o_d(w_d_d), .o_v(w_d_v)
  );

  // tlbp probes with EntryHi; page data is irrelevant so the odd bit is tied.
  tlb_lookup #(.N(TLB_LINE_NUM), .IDX_W(IDX_W)) u_lkp_probe (
    .i_entries(r_entries), .i_vpn2(entry_hi_W[VPN2_LSB +: VPN2_BITS]), .i_odd(1'b0),
    .i_asid(w_asid), .o_hit(w_p_hit), .o_idx(w_p_idx), .o_pfn(w_p_pfn),
    .o_c(w_p_c), .o_d(w_p_d), .o_v(w_p_v)
  );

  // ---------------- instruction port ----------------
  logic w_i_unmapped;
  assign w_i_unmapped = is_unmapped(inst_vaddr);

  always_comb begin
    inst_refill  = 1'b0;
    inst_invalid = 1'b0;
    if (w_i_unmapped) begin
      inst_paddr    = {3'b0, inst_vaddr[28:0]};
      inst_uncached = is_kseg1(inst_vaddr) || (k0 == CACHE_UNCACHED);
    end else begin
      inst_paddr    = {w_i_pfn, inst_vaddr[11:0]};
      inst_uncached = (w_i_c == CACHE_UNCACHED);
      inst_refill   = ~w_i_hit;
      inst_invalid  = w_i_hit & ~w_i_v;
    end
  end

  // ---------------- data port ----------------
  logic w_d_unmapped;
  assign w_d_unmapped = is_unmapped(data_vaddr);

  always_comb begin
    data_refill  = 1'b0;
    data_invalid = 1'b0;
    data_modify  = 1'b0;
    if (w_d_unmapped) begin
      data_paddr    = {3'b0, data_vaddr[28:0]};
      data_uncached = is_kseg1(data_vaddr) || (k0 == CACHE_UNCACHED);
    end else begin
      data_paddr    = {w_d_pfn, data_vaddr[11:0]};
      data_uncached = (w_d_c == CACHE_UNCACHED);
      data_refill   = ~w_d_hit;
      data_invalid  = w_d_hit & ~w_d_v;
      data_modify   = w_d_hit & w_d_v & data_store & ~w_d_d;
    end
  end

  // ---------------- tlbp / tlbr ----------------
  tlb_entry_t w_rd;
  assign w_rd = r_entries[index_W[IDX_W-1:0]];

  assign index_in     = w_p_hit ? 32'(w_p_idx) : 32'h8000_0000;
  assign entry_hi_in  = {w_rd.vpn2, 5'b0, w_rd.asid};
  assign page_mask_in = {3'b0, w_rd.mask, 13'b0};
  assign entry_lo0_in = {6'b0, w_rd.pfn0, w_rd.c0, w_rd.d0, w_rd.v0, w_rd.g};
  assign entry_lo1_in = {6'b0, w_rd.pfn1, w_rd.c1, w_rd.d1, w_rd.v1, w_rd.g};

  // ---------------- tlbwi / tlbwr ----------------
  logic             w_we;
  logic [IDX_W-1:0] w_widx;
  tlb_entry_t       w_new;
  logic [MASK_BITS-1:0] w_mask;

  assign w_we   = (tlb_typeM[3] | tlb_typeM[2]) & ~stallW & ~flush_exception;
  assign w_widx = tlb_typeM[2] ? index_W[IDX_W-1:0] : random_W[IDX_W-1:0];
  assign w_mask = page_mask_W[MASK_LSB +: MASK_BITS];

  always_comb begin
    w_new      = '0;
    w_new.mask = w_mask;
    // VPN2 is stored pre-masked so tlbr returns zeros in the don't-care bits.
    w_new.vpn2 = entry_hi_W[VPN2_LSB +: VPN2_BITS] & ~{3'b0, w_mask};
    w_new.asid = w_asid;
    w_new.g    = entry_lo0_W[LO_G] & entry_lo1_W[LO_G];
    w_new.pfn0 = entry_lo0_W[PFN_LSB +: PFN_BITS];
    w_new.c0   = entry_lo0_W[LO_C +: 3];
    w_new.d0   = entry_lo0_W[LO_D];
    w_new.v0   = entry_lo0_W[LO_V];
    w_new.pfn1 = entry_lo1_W[PFN_LSB +: PFN_BITS];
    w_new.c1   = entry_lo1_W[LO_C +: 3];
    w_new.d1   = entry_lo1_W[LO_D];
    w_new.v1   = entry_lo1_W[LO_V];
  end

  always_ff @(posedge clk) begin
    if (rst)       r_entries         <= '0;
    else if (w_we) r_entries[w_widx] <= w_new;
  end

  // Register bits that the TLB has no use for.
  logic w_unused;
  assign w_unused = ^{entry_hi_W[12:8], page_mask_W[31:29], page_mask_W[12:0],
                      entry_lo0_W[31:26], entry_lo1_W[31:26],
                      index_W[31:IDX_W], random_W[31:IDX_W], tlb_typeM[1:0],
                      w_i_idx, w_d_idx, w_p_pfn, w_p_c, w_p_d, w_p_v};

endmodule

// File: tb/tb_tlb_unit.sv
module tb_tlb_unit;

  logic        clk = 1'b0;
  logic        rst, stallW, flush_exception, data_store;
  logic [3:0]  tlb_typeM;
  logic [31:0] entry_hi_W, page_mask_W, entry_lo0_W, entry_lo1_W, index_W, random_W;
  logic [2:0]  k0;
  logic [31:0] inst_vaddr, data_vaddr, inst_paddr, data_paddr;
  logic        inst_uncached, data_uncached, inst_refill, inst_invalid;
  logic        data_refill, data_invalid, data_modify;
  logic [31:0] entry_hi_in, page_mask_in, entry_lo0_in, entry_lo1_in, index_in;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tlb_unit #(.TLB_LINE_NUM(32), .IDX_W(5)) dut (
    .clk(clk), .rst(rst), .stallW(stallW), .flush_exception(flush_exception),
    .tlb_typeM(tlb_typeM), .entry_hi_W(entry_hi_W), .page_mask_W(page_mask_W),
    .entry_lo0_W(entry_lo0_W), .entry_lo1_W(entry_lo1_W), .index_W(index_W),
    .random_W(random_W), .k0(k0), .inst_vaddr(inst_vaddr), .data_vaddr(data_vaddr),
    .data_store(data_store), .inst_paddr(inst_paddr), .data_paddr(data_paddr),
    .inst_uncached(inst_uncached), .data_uncached(data_uncached),
    .inst_refill(inst_refill), .inst_invalid(inst_invalid),
    .data_refill(data_refill), .data_invalid(data_invalid), .data_modify(data_modify),
    .entry_hi_in(entry_hi_in), .page_mask_in(page_mask_in),
    .entry_lo0_in(entry_lo0_in), .entry_lo1_in(entry_lo1_in), .index_in(index_in)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // One-cycle tlbwi (wr=0) or tlbwr (wr=1) to index idx.
  task automatic tlb_write(input logic wr, input logic [31:0] idx, input logic [31:0] hi,
                           input logic [31:0] pm, input logic [31:0] lo0, input logic [31:0] lo1);
    tlb_typeM   = wr ? 4'b1000 : 4'b0100;
    index_W     = wr ? 32'd3 : idx;
    random_W    = wr ? idx : 32'd3;
    entry_hi_W  = hi;
    page_mask_W = pm;
    entry_lo0_W = lo0;
    entry_lo1_W = lo1;
    tick();
    tlb_typeM   = 4'b0000;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    entry_hi_W = 32'h0; k0 = 3'd3; data_store = 1'b0;
    inst_vaddr = 32'hBFC0_0000; data_vaddr = 32'h8000_1000; #1;
    n_vec++; if (inst_paddr !== 32'h1FC0_0000) begin n_err++; $display("FAIL kseg1_paddr: got %h want 1fc00000", inst_paddr); end
    n_vec++; if ({inst_refill, inst_invalid, inst_uncached} !== 3'b001) begin n_err++; $display("FAIL kseg1_flags: got %b want 001", {inst_refill, inst_invalid, inst_uncached}); end
    n_vec++; if (data_paddr !== 32'h0000_1000) begin n_err++; $display("FAIL kseg0_paddr: got %h want 00001000", data_paddr); end
    n_vec++; if ({data_refill, data_invalid, data_modify, data_uncached} !== 4'b0000) begin n_err++; $display("FAIL kseg0_flags: got %b want 0000", {data_refill, data_invalid, data_modify, data_uncached}); end
    k0 = 3'd2; #1;
    n_vec++; if (data_uncached !== 1'b1) begin n_err++; $display("FAIL kseg0_k0_unc: got %b want 1", data_uncached); end
    k0 = 3'd3; data_vaddr = 32'h0000_1000; data_store = 1'b1; #1;
    n_vec++; if ({data_refill, data_invalid, data_modify} !== 3'b010) begin n_err++; $display("FAIL reset_entry0_invalid: got %b want 010", {data_refill, data_invalid, data_modify}); end
    data_store = 1'b0; data_vaddr = 32'h0040_0000; #1;
    n_vec++; if ({data_refill, data_invalid, data_modify} !== 3'b100) begin n_err++; $display("FAIL reset_refill: got %b want 100", {data_refill, data_invalid, data_modify}); end
    index_W = 32'd0; #1;
    n_vec++; if ({entry_hi_in, page_mask_in, entry_lo0_in, entry_lo1_in} !== 128'h0) begin n_err++; $display("FAIL reset_tlbr0: got %h %h %h %h want zeros", entry_hi_in, page_mask_in, entry_lo0_in, entry_lo1_in); end
  endtask

  task automatic test_tlbwi();
    tlb_write(1'b0, 32'd5, 32'h0040_0012, 32'h0, 32'h0000_48DE, 32'h0);
    // probe in the very next cycle
    tlb_typeM = 4'b0001; entry_hi_W = 32'h0040_0012; #1;
    n_vec++; if (index_in !== 32'd5) begin n_err++; $display("FAIL tlbp_after_tlbwi: got %h want 5", index_in); end
    tlb_typeM = 4'b0000;
    data_vaddr = 32'h0040_0ABC; inst_vaddr = 32'h0040_0ABC; #1;
    n_vec++; if (data_paddr !== 32'h0012_3ABC) begin n_err++; $display("FAIL wi_data_paddr: got %h want 00123abc", data_paddr); end
    n_vec++; if ({data_refill, data_invalid, data_modify, data_uncached} !== 4'b0000) begin n_err++; $display("FAIL wi_data_flags: got %b want 0000", {data_refill, data_invalid, data_modify, data_uncached}); end
    n_vec++; if (inst_paddr !== 32'h0012_3ABC) begin n_err++; $display("FAIL wi_inst_paddr: got %h want 00123abc", inst_paddr); end
    n_vec++; if ({inst_refill, inst_invalid, inst_uncached} !== 3'b000) begin n_err++; $display("FAIL wi_inst_flags: got %b want 000", {inst_refill, inst_invalid, inst_uncached}); end
    data_vaddr = 32'h0040_1ABC; #1;
    n_vec++; if ({data_refill, data_invalid, data_modify} !== 3'b010) begin n_err++; $display("FAIL wi_odd_invalid: got %b want 010", {data_refill, data_invalid, data_modify}); end
    data_vaddr = 32'h0040_0ABC; entry_hi_W = 32'h0040_0013; #1;
    n_vec++; if ({data_refill, data_invalid, data_modify} !== 3'b100) begin n_err++; $display("FAIL wi_asid_refill: got %b want 100", {data_refill, data_invalid, data_modify}); end
    entry_hi_W = 32'h0040_0012;
  endtask

  task automatic test_store();
    tlb_write(1'b0, 32'd6, 32'h0060_0012, 32'h0, 32'h0001_1592, 32'h0);
    data_vaddr = 32'h0060_0010; data_store = 1'b1; #1;
    n_vec++; if (data_paddr !== 32'h0045_6010) begin n_err++; $display("FAIL store_paddr: got %h want 00456010", data_paddr); end
    n_vec++; if ({data_refill, data_invalid, data_modify, data_uncached} !== 4'b0011) begin n_err++; $display("FAIL store_modify: got %b want 0011", {data_refill, data_invalid, data_modify, data_uncached}); end
    data_store = 1'b0; #1;
    n_vec++; if ({data_refill, data_invalid, data_modify, data_uncached} !== 4'b0001) begin n_err++; $display("FAIL load_no_exc: got %b want 0001", {data_refill, data_invalid, data_modify, data_uncached}); end
  endtask

  task automatic test_tlbp_tlbr();
    tlb_typeM = 4'b0001; entry_hi_W = 32'h0040_0012; #1;
    n_vec++; if (index_in !== 32'd5) begin n_err++; $display("FAIL tlbp_hit: got %h want 5", index_in); end
    entry_hi_W = 32'h7000_0012; #1;
    n_vec++; if (index_in !== 32'h8000_0000) begin n_err++; $display("FAIL tlbp_miss: got %h want 80000000", index_in); end
    tlb_typeM = 4'b0010; index_W = 32'd5; #1;
    n_vec++; if (entry_lo0_in !== 32'h0000_48DE) begin n_err++; $display("FAIL tlbr_lo0: got %h want 000048de", entry_lo0_in); end
    n_vec++; if (entry_hi_in !== 32'h0040_0012) begin n_err++; $display("FAIL tlbr_hi: got %h want 00400012", entry_hi_in); end
    n_vec++; if ({entry_lo1_in, page_mask_in} !== 64'h0) begin n_err++; $display("FAIL tlbr_lo1_pm: got %h %h want 0 0", entry_lo1_in, page_mask_in); end
    tlb_typeM = 4'b0000; entry_hi_W = 32'h0040_0012;
  endtask

  task automatic test_tlbwr();
    tlb_write(1'b1, 32'd17, 32'h1234_6022, 32'h0, 32'h0002_AF1F, 32'h0002_AF5B);
    index_W = 32'd17; #1;
    n_vec++; if (entry_hi_in !== 32'h1234_6022) begin n_err++; $display("FAIL wr_hi: got %h want 12346022", entry_hi_in); end
    n_vec++; if (entry_lo0_in !== 32'h0002_AF1F) begin n_err++; $display("FAIL wr_lo0: got %h want 0002af1f", entry_lo0_in); end
    n_vec++; if (entry_lo1_in !== 32'h0002_AF5B) begin n_err++; $display("FAIL wr_lo1: got %h want 0002af5b", entry_lo1_in); end
    index_W = 32'd3; #1;
    n_vec++; if (entry_hi_in !== 32'h0) begin n_err++; $display("FAIL wr_not_index: got %h want 0", entry_hi_in); end
    // global entry matches any ASID; odd page has D=0
    entry_hi_W = 32'h0000_0099; data_vaddr = 32'h1234_7000; data_store = 1'b1; #1;
    n_vec++; if (data_paddr !== 32'h00AB_D000) begin n_err++; $display("FAIL global_paddr: got %h want 00abd000", data_paddr); end
    n_vec++; if ({data_refill, data_invalid, data_modify} !== 3'b001) begin n_err++; $display("FAIL global_modify: got %b want 001", {data_refill, data_invalid, data_modify}); end
    data_store = 1'b0;
    flush_exception = 1'b1;
    tlb_write(1'b1, 32'd17, 32'h5555_4000, 32'h0, 32'h0000_003F, 32'h0000_003F);
    flush_exception = 1'b0; index_W = 32'd17; #1;
    n_vec++; if (entry_hi_in !== 32'h1234_6022) begin n_err++; $display("FAIL wr_flush_held: got %h want 12346022", entry_hi_in); end
    stallW = 1'b1;
    tlb_write(1'b1, 32'd17, 32'h5555_4000, 32'h0, 32'h0000_003F, 32'h0000_003F);
    stallW = 1'b0; index_W = 32'd17; #1;
    n_vec++; if (entry_lo0_in !== 32'h0002_AF1F) begin n_err++; $display("FAIL wr_stall_held: got %h want 0002af1f", entry_lo0_in); end
    entry_hi_W = 32'h0040_0012;
  endtask

  task automatic test_mask();
    tlb_write(1'b0, 32'd10, 32'h0100_6012, 32'h0000_6000, 32'h0000_C85E, 32'h0);
    index_W = 32'd10; #1;
    n_vec++; if (entry_hi_in !== 32'h0100_0012) begin n_err++; $display("FAIL mask_hi: got %h want 01000012", entry_hi_in); end
    n_vec++; if (page_mask_in !== 32'h0000_6000) begin n_err++; $display("FAIL mask_pm: got %h want 00006000", page_mask_in); end
    entry_hi_W = 32'h0000_0012; data_vaddr = 32'h0100_6000; #1;
    n_vec++; if ({data_paddr, data_refill, data_invalid} !== {32'h0032_1000, 2'b00}) begin n_err++; $display("FAIL mask_hit: got %h %b%b want 00321000 00", data_paddr, data_refill, data_invalid); end
    data_vaddr = 32'h0100_8000; #1;
    n_vec++; if (data_refill !== 1'b1) begin n_err++; $display("FAIL mask_outside: got %b want 1", data_refill); end
  endtask

  task automatic test_priority();
    tlb_write(1'b0, 32'd2, 32'h0, 32'h0, 32'h0000_0002, 32'h0);
    entry_hi_W = 32'h0; data_vaddr = 32'h0000_0100; #1;
    n_vec++; if ({data_refill, data_invalid} !== 2'b01) begin n_err++; $display("FAIL prio_lowest: got %b want 01", {data_refill, data_invalid}); end
    tlb_typeM = 4'b0001; #1;
    n_vec++; if (index_in !== 32'd0) begin n_err++; $display("FAIL prio_tlbp: got %h want 0", index_in); end
    tlb_typeM = 4'b0000;
  endtask

  task automatic test_back_to_back();
    entry_hi_W = 32'h0080_0012; page_mask_W = 32'h0; data_vaddr = 32'h0080_0000;
    tlb_typeM = 4'b0100; index_W = 32'd7; entry_lo0_W = 32'h0001_DDDE; entry_lo1_W = 32'h0; #1;
    n_vec++; if ({data_refill, data_invalid} !== 2'b10) begin n_err++; $display("FAIL same_cycle_old: got %b want 10", {data_refill, data_invalid}); end
    tick(); tlb_typeM = 4'b0000; #1;
    n_vec++; if ({data_paddr, data_refill, data_invalid} !== {32'h0077_7000, 2'b00}) begin n_err++; $display("FAIL next_cycle_new: got %h %b%b want 00777000 00", data_paddr, data_refill, data_invalid); end
  endtask

  task automatic test_reset_write();
    rst = 1'b1;
    tlb_typeM = 4'b0100; index_W = 32'd9; entry_hi_W = 32'h00A0_0012; entry_lo0_W = 32'h2; entry_lo1_W = 32'h2;
    tick();
    rst = 1'b0; tlb_typeM = 4'b0000;
    for (int i = 0; i < 32; i++) begin
      index_W = i; #1;
      n_vec++; if ({entry_hi_in, page_mask_in, entry_lo0_in, entry_lo1_in} !== 128'h0) begin n_err++; $display("FAIL rst_wins_entry%0d: got %h %h %h %h want zeros", i, entry_hi_in, page_mask_in, entry_lo0_in, entry_lo1_in); end
    end
    data_vaddr = 32'h00A0_0000; #1;
    n_vec++; if (data_refill !== 1'b1) begin n_err++; $display("FAIL rst_wins_lookup: got %b want 1", data_refill); end
  endtask

  initial begin
    rst = 1'b1; stallW = 1'b0; flush_exception = 1'b0; data_store = 1'b0;
    tlb_typeM = 4'b0; entry_hi_W = '0; page_mask_W = '0; entry_lo0_W = '0; entry_lo1_W = '0;
    index_W = '0; random_W = '0; k0 = 3'd3; inst_vaddr = '0; data_vaddr = '0;
    test_reset();
    test_tlbwi();
    test_store();
    test_tlbp_tlbr();
    test_tlbwr();
    test_mask();
    test_priority();
    test_back_to_back();
    test_reset_write();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
